pwm_output_stage: RTL and testbench

Audio output stage directly downstream of the sequential divider. It accepts 8-bit unsigned samples, such as the divider's `quotient`, through a valid/ready handshake and buffers one sample in a holding register. Each held sample is converted into a 256-cycle pulse-width-modulated frame on a single pin that drives the external speaker filter. It reports the frame boundaries that pace upstream sample production, and it flags underruns.

---
 rtl/pwm_output_stage_if.sv | 22 ++
 rtl/pwm_output_stage.sv | 76 +++++++
 tb/tb_pwm_output_stage.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_output_stage_if.sv
// Sample handshake, run control and PWM status bundle for pwm_output_stage.
// master = upstream/controller side, slave = the output stage itself.
interface pwm_output_stage_if;
   logic       en;
   logic [7:0] sample_in;
   logic       sample_valid;
   logic       sample_ready;
   logic       pwm_out;
   logic       frame_strobe;
   logic       underrun;
   logic       clr_underrun;

   modport master (
      output en, sample_in, sample_valid, clr_underrun,
      input  sample_ready, pwm_out, frame_strobe, underrun
   );

   modport slave (
      input  en, sample_in, sample_valid, clr_underrun,
      output sample_ready, pwm_out, frame_strobe, underrun
   );
endinterface

// File: rtl/pwm_output_stage.sv
// 8-bit sample -> 256-cycle PWM frame; pwm_out lags the counter by 1 cycle, new duty lands at frame end.
// One-entry holding buffer: sample_ready drops while it is full, so upstream stalls until the next frame boundary.
module pwm_output_stage (
   input  logic              clk,
   input  logic              nRst,
   pwm_output_stage_if.slave bus
);
   logic [7:0] r_cnt;
   logic [7:0] r_duty;
   logic [7:0] r_hold;
   logic       r_hold_full;
   logic       r_pwm;
   logic       r_strobe;
   logic       r_underrun;

   logic       w_xfer;
   logic       w_boundary;
   logic       w_underrun_evt;

   assign w_xfer         = bus.sample_valid && !r_hold_full;
   assign w_boundary     = bus.en && (r_cnt == 8'hFF);
   assign w_underrun_evt = w_boundary && !r_hold_full && !w_xfer;

   assign bus.sample_ready = !r_hold_full;
   assign bus.pwm_out      = r_pwm;
   assign bus.frame_strobe = r_strobe;
   assign bus.underrun     = r_underrun;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_cnt    <= 8'd0;
         r_pwm    <= 1'b0;
         r_strobe <= 1'b0;
      end else begin
         r_strobe <= w_boundary;
         if (bus.en) begin
            r_cnt <= r_cnt + 8'd1;
            r_pwm <= (r_cnt < r_duty);
         end else begin
            r_cnt <= 8'd0;
            r_pwm <= 1'b0;
         end
      end
   end

   // While idle the buffer drains straight into duty so duty tracks the newest sample.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_duty      <= 8'd0;
         r_hold      <= 8'd0;
         r_hold_full <= 1'b0;
      end else if (r_hold_full) begin
         if (!bus.en || w_boundary) begin
            r_duty      <= r_hold;
            r_hold_full <= 1'b0;
         end
      end else if (w_xfer) begin
         r_hold <= bus.sample_in;
         if (w_boundary) begin
            r_duty <= bus.sample_in;
         end else begin
            r_hold_full <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_underrun <= 1'b0;
      end else if (w_underrun_evt) begin
         r_underrun <= 1'b1;
      end else if (bus.clr_underrun) begin
         r_underrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pwm_output_stage.sv
// Randomized + scenario bench for pwm_output_stage against a frame-level reference model.
module tb_pwm_output_stage;
   logic clk = 1'b0;
   logic nRst;

   pwm_output_stage_if bus();

   pwm_output_stage dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: frame position, active duty, buffer as a queue, sticky flag.
   int m_pos;
   int m_duty;
   int m_buf[$];
   int m_underrun;
   int m_hi;
   int m_fduty;
   bit m_framed;
   bit m_acc;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pos = 0;
      m_duty = 0;
      m_buf.delete();
      m_underrun = 0;
      m_hi = 0;
      m_fduty = 0;
      m_framed = 0;
      m_acc = 0;
   endtask

   task automatic cyc();
      bit en, xfer, bnd, clr, evt;
      int p, d, s;
      en   = bus.en;
      clr  = bus.clr_underrun;
      s    = int'(bus.sample_in);
      p    = m_pos;
      d    = m_duty;
      xfer = bus.sample_valid && (m_buf.size() == 0);
      bnd  = en && (p == 255);
      evt  = 0;
      @(posedge clk);
      #1;
      m_acc = xfer;
      if (en) begin
         if (bnd) begin
            if (m_buf.size() != 0) m_duty = m_buf.pop_front();
            else if (xfer) m_duty = s;
            else begin
               m_underrun = 1;
               evt = 1;
            end
         end else if (xfer) begin
            m_buf.push_back(s);
         end
         m_pos = (p + 1) % 256;
      end else begin
         m_pos = 0;
         if (m_buf.size() != 0) m_duty = m_buf.pop_front();
         else if (xfer) m_buf.push_back(s);
      end
      if (clr && !evt) m_underrun = 0;

      chk("ready", bus.sample_ready, m_buf.size() == 0);
      chk("strobe", bus.frame_strobe, bnd);
      chk("underrun", bus.underrun, m_underrun);
      if (en) begin
         chk("pwm", bus.pwm_out, p < d);
         if (p == 0) begin
            m_framed = 1;
            m_hi = 0;
            m_fduty = d;
         end
         m_hi += int'(bus.pwm_out);
         if (p == 255 && m_framed) chk("frame_hi", m_hi, m_fduty);
      end else begin
         chk("pwm_idle", bus.pwm_out, 0);
         m_framed = 0;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         if (m_acc) bus.sample_valid = 1'b0;
      end
   endtask

   task automatic run_to(input int pos);
      for (int i = 0; i < 600 && m_pos != pos; i++) run(1);
      if (m_pos != pos) chk("run_to_timeout", m_pos, pos);
   endtask

   task automatic send(input int v);
      bus.sample_in = 8'(v);
      bus.sample_valid = 1'b1;
   endtask

   int strobes;
   int busy;
   int hi;

   initial begin
      nRst = 1'b0;
      bus.en = 1'b0;
      bus.sample_in = 8'd0;
      bus.sample_valid = 1'b0;
      bus.clr_underrun = 1'b0;
      model_reset();
      #12;
      chk("rst_ready", bus.sample_ready, 1);
      chk("rst_pwm", bus.pwm_out, 0);
      chk("rst_strobe", bus.frame_strobe, 0);
      chk("rst_underrun", bus.underrun, 0);
      @(negedge clk);
      nRst = 1'b1;

      // Basic duty: 64 loaded while idle, refreshed mid-frame so no underrun.
      send(64);
      run(2);
      bus.en = 1'b1;
      strobes = 0;
      for (int i = 0; i < 768; i++) begin
         if (m_pos == 128 && !bus.sample_valid) send(64);
         run(1);
         strobes += int'(bus.frame_strobe);
      end
      chk("basic_strobes", strobes, 3);
      chk("basic_underrun", bus.underrun, 0);

      // Back-pressure: 10 at cnt=5, then 20 held until the buffer frees.
      run_to(5);
      send(10);
      run(1);
      send(20);
      busy = 0;
      for (int i = 0; i < 600 && bus.sample_valid; i++) begin
         if (!bus.sample_ready) busy++;
         run(1);
      end
      chk("bp_busy", busy, 250);
      run(512);
      bus.clr_underrun = 1'b1;
      run(1);
      bus.clr_underrun = 1'b0;
      chk("bp_clr", bus.underrun, 0);

      // Bypass at the boundary, then a repeat frame with underrun.
      run_to(255);
      send(128);
      run(1);
      chk("bypass_underrun", bus.underrun, 0);
      run(256);
      chk("repeat_underrun", bus.underrun, 1);
      run(256);
      bus.clr_underrun = 1'b1;
      run(1);
      bus.clr_underrun = 1'b0;
      chk("clr_underrun", bus.underrun, 0);

      // Clear coinciding with an underrun boundary loses to the set.
      run_to(255);
      bus.clr_underrun = 1'b1;
      run(1);
      bus.clr_underrun = 1'b0;
      chk("set_over_clr", bus.underrun, 1);

      // Enable abort at cnt=100 with duty=255, then a clean restart.
      send(255);
      run(1);
      run_to(0);
      run_to(100);
      bus.en = 1'b0;
      run(1);
      chk("abort_pwm", bus.pwm_out, 0);
      run(2);
      bus.en = 1'b1;
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         run(1);
         hi += int'(bus.pwm_out);
      end
      chk("abort_hi", hi, 255);

      // Mid-frame reset with duty=200 and a pending sample in the buffer.
      send(200);
      run(1);
      run_to(0);
      send(99);
      run(1);
      run(50);
      #2 nRst = 1'b0;
      #1;
      chk("mrst_ready", bus.sample_ready, 1);
      chk("mrst_pwm", bus.pwm_out, 0);
      chk("mrst_strobe", bus.frame_strobe, 0);
      chk("mrst_underrun", bus.underrun, 0);
      model_reset();
      bus.sample_valid = 1'b0;
      #2 nRst = 1'b1;
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         run(1);
         hi += int'(bus.pwm_out);
      end
      chk("mrst_frame_hi", hi, 0);

      // Random traffic, clears and enable toggles.
      for (int i = 0; i < 8000; i++) begin
         if (!bus.sample_valid && $urandom_range(0, 299) < 2) send(int'($urandom_range(0, 255)));
         bus.clr_underrun = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 1499) == 0) bus.en = ~bus.en;
         run(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
